// File: rtl/meteor_game_ctrl_if.sv
// Signal bundle between the meteor game controller and its surroundings
// (motion block, VGA frame clock, keyboard, display).
interface meteor_game_ctrl_if;
  logic        frame_clk;
  logic        collide;
  logic [7:0]  keycode;
  logic        game_reset;
  logic        freeze;
  logic        game_over;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [1:0]  state;

  modport master (
    output frame_clk, collide, keycode,
    input  game_reset, freeze, game_over, lives, score, state
  );

  modport slave (
    input  frame_clk, collide, keycode,
    output game_reset, freeze, game_over, lives, score, state
  );
endinterface

// File: rtl/meteor_game_ctrl.sv
// Game-level controller: lives, BCD score and the IDLE/PLAY/HIT/OVER flow,
// driving the motion block's reset and the freeze/score/lives display info.
module meteor_game_ctrl #(
  parameter int         LIVES_INIT = 3,
  parameter int         HIT_FRAMES = 60,
  parameter int         SCORE_DIV  = 30,
  parameter logic [7:0] START_KEY  = 8'h2C
) (
  input logic           Clk,
  input logic           Reset_n,
  meteor_game_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic [1:0] LIVES_LOAD = 2'(LIVES_INIT);
  localparam logic [7:0] DIV_LAST   = 8'(SCORE_DIV - 1);
  localparam logic [7:0] HIT_LAST   = 8'(HIT_FRAMES);

  state_t      state_q, state_n;
  logic [1:0]  lives_q, lives_n;
  logic [15:0] score_q, score_n;
  logic [7:0]  frame_div_q, frame_div_n;
  logic [7:0]  hit_cnt_q, hit_cnt_n;
  logic        game_reset_q, game_reset_n;
  logic        freeze_q, freeze_n;
  logic        game_over_q, game_over_n;
  logic        respawn;

  logic [2:0]  frame_sync;
  logic [2:0]  collide_sync;
  logic [7:0]  key_prev;
  logic        tick, hit, start;

  // Third stage of each chain only remembers the previous synced value for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_sync   <= 3'b000;
      collide_sync <= 3'b000;
      key_prev     <= 8'h00;
    end else begin
      frame_sync   <= {frame_sync[1:0], bus.frame_clk};
      collide_sync <= {collide_sync[1:0], bus.collide};
      key_prev     <= bus.keycode;
    end
  end

  assign tick  = frame_sync[1] & ~frame_sync[2];
  assign hit   = collide_sync[1] & ~collide_sync[2];
  assign start = (bus.keycode == START_KEY) && (key_prev != START_KEY);

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      lives_q      <= LIVES_LOAD;
      score_q      <= 16'h0000;
      frame_div_q  <= 8'd0;
      hit_cnt_q    <= 8'd0;
      game_reset_q <= 1'b1;
      freeze_q     <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_n;
      lives_q      <= lives_n;
      score_q      <= score_n;
      frame_div_q  <= frame_div_n;
      hit_cnt_q    <= hit_cnt_n;
      game_reset_q <= game_reset_n;
      freeze_q     <= freeze_n;
      game_over_q  <= game_over_n;
    end
  end

  // A hit in PLAY takes precedence over a coincident tick, so the score never advances on it.
  always_comb begin
    state_n     = state_q;
    lives_n     = lives_q;
    score_n     = score_q;
    frame_div_n = frame_div_q;
    hit_cnt_n   = hit_cnt_q;
    respawn     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_n     = PLAY;
          score_n     = 16'h0000;
          lives_n     = LIVES_LOAD;
          frame_div_n = 8'd0;
        end
      end
      PLAY: begin
        if (hit) begin
          if (lives_q <= 2'd1) begin
            state_n = OVER;
            lives_n = 2'd0;
          end else begin
            state_n   = HIT;
            lives_n   = lives_q - 2'd1;
            hit_cnt_n = 8'd0;
          end
        end else if (tick) begin
          if (frame_div_q == DIV_LAST) begin
            frame_div_n = 8'd0;
            score_n     = bcd_inc(score_q);
          end else begin
            frame_div_n = frame_div_q + 8'd1;
          end
        end
      end
      HIT: begin
        if (tick) begin
          if (hit_cnt_q + 8'd1 == HIT_LAST) begin
            state_n   = PLAY;
            hit_cnt_n = 8'd0;
            respawn   = 1'b1;
          end else begin
            hit_cnt_n = hit_cnt_q + 8'd1;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    game_reset_n = (state_n == IDLE) || (state_n == OVER) || respawn;
    freeze_n     = (state_n != PLAY);
    game_over_n  = (state_n == OVER);
  end

  assign bus.state      = state_q;
  assign bus.lives      = lives_q;
  assign bus.score      = score_q;
  assign bus.game_reset = game_reset_q;
  assign bus.freeze     = freeze_q;
  assign bus.game_over  = game_over_q;

endmodule
